mix_columns_engine: RTL and testbench

Sequential, parametrised MixColumns engine for the AES datapath. It accepts a full 128-bit AES state over a valid/ready handshake and applies forward MixColumns or InvMixColumns, selected per block. It processes COLS_PER_CYCLE columns per clock and returns the result over a second valid/ready handshake. It sits between ShiftRows/InvShiftRows and AddRoundKey in the round pipeline. It supersedes the single-column combinational calculation, which becomes its internal column unit.

---
 rtl/aes_pkg.sv | 31 +++
 rtl/mix_columns_engine_unit.sv | 69 ++++++
 rtl/mix_columns_engine.sv | 116 +++++++++++
 tb/tb_mix_columns_engine.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types, GF(2^8) xtime helper and column indexing.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_col_t;
  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // MSB bit position of column c within a 128-bit state (column 0 at the top)
  function automatic logic [6:0] col_msb(input logic [1:0] c);
    return 7'd127 - {c, 5'd0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_columns_engine_unit.sv
`default_nettype none
// ============================================================================
// Module      : mix_column_unit
// Description : Combinational single-column MixColumns / InvMixColumns.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_column_unit
  import aes_pkg::*;
#(
  parameter bit ENABLE_INV = 1'b1
) (
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] col_out
);

  aes_byte_t w_a  [4];
  aes_byte_t w_x2 [4];
  aes_col_t  w_fwd;

  always_comb begin
    w_fwd = '0;
    for (int i = 0; i < 4; i++) begin
      w_a[i]  = col[31-8*i -: 8];
      w_x2[i] = xtime(w_a[i]);
    end
    // Row i: 02*a[i] ^ 03*a[i+1] ^ a[i+2] ^ a[i+3]
    for (int i = 0; i < 4; i++) begin
      w_fwd[31-8*i -: 8] = w_x2[i] ^ w_x2[(i+1)%4] ^ w_a[(i+1)%4]
                         ^ w_a[(i+2)%4] ^ w_a[(i+3)%4];
    end
  end

  generate
    if (ENABLE_INV) begin : g_inv
      aes_byte_t w_x4 [4];
      aes_byte_t w_x8 [4];
      aes_byte_t w_m9 [4];
      aes_byte_t w_mb [4];
      aes_byte_t w_md [4];
      aes_byte_t w_me [4];
      aes_col_t  w_inv_col;

      always_comb begin
        w_inv_col = '0;
        for (int i = 0; i < 4; i++) begin
          w_x4[i] = xtime(w_x2[i]);
          w_x8[i] = xtime(w_x4[i]);
          w_m9[i] = w_x8[i] ^ w_a[i];
          w_mb[i] = w_x8[i] ^ w_x2[i] ^ w_a[i];
          w_md[i] = w_x8[i] ^ w_x4[i] ^ w_a[i];
          w_me[i] = w_x8[i] ^ w_x4[i] ^ w_x2[i];
        end
        for (int i = 0; i < 4; i++) begin
          w_inv_col[31-8*i -: 8] = w_me[i] ^ w_mb[(i+1)%4]
                                 ^ w_md[(i+2)%4] ^ w_m9[(i+3)%4];
        end
      end

      assign col_out = inv ? w_inv_col : w_fwd;
    end else begin : g_no_inv
      logic w_unused_inv;
      assign w_unused_inv = inv;
      assign col_out      = w_fwd;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mix_columns_engine.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_engine
// Description : Sequential MixColumns/InvMixColumns engine with handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit ENABLE_INV     = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         out_inv
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] c_step = 2'(COLS_PER_CYCLE);

  mc_state_t  r_state;
  mc_state_t  w_state_nxt;
  logic [1:0] r_cnt;
  aes_state_t r_work;
  aes_state_t w_work_nxt;
  logic       r_inv;
  logic       w_accept;
  logic       w_last;

  logic [1:0] w_idx     [COLS_PER_CYCLE];
  aes_col_t   w_col_in  [COLS_PER_CYCLE];
  aes_col_t   w_col_out [COLS_PER_CYCLE];

  generate
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
      assign w_idx[k]    = r_cnt + 2'(k);
      assign w_col_in[k] = r_work[col_msb(w_idx[k]) -: 32];

      mix_column_unit #(
        .ENABLE_INV (ENABLE_INV)
      ) u_unit (
        .col     (w_col_in[k]),
        .inv     (r_inv),
        .col_out (w_col_out[k])
      );
    end
  endgenerate

  always_comb begin
    w_work_nxt = r_work;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      w_work_nxt[col_msb(w_idx[k]) -: 32] = w_col_out[k];
    end
  end

  // The last column of the block is handled on this edge
  assign w_last   = ({1'b0, r_cnt} + 3'(COLS_PER_CYCLE)) == 3'd4;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? BUSY : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
      r_work  <= '0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_work <= in_state;
        r_inv  <= in_inv & ENABLE_INV;
        r_cnt  <= 2'd0;
      end else if (r_state == BUSY) begin
        r_work <= w_work_nxt;
        r_cnt  <= r_cnt + c_step;
      end
    end
  end

  assign out_state = r_work;
  assign out_inv   = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mix_columns_engine
// Description : Directed self-checking bench for mix_columns_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_columns_engine;

  localparam logic [127:0] c_fips_in  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] c_fips_out = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] c_x        = 128'hDB135345F20A225CD4D4D4D52D26314C;
  localparam logic [127:0] c_y        = 128'h8E4DA1BC9FDC589DD5D5D7D64D7EBDF8;

  logic         clk;
  logic         rst;
  // index 0: COLS=1, 1: COLS=2, 2: COLS=4, 3: COLS=1 without inverse path
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic [127:0] in_state  [4];
  logic         in_inv    [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [127:0] out_state [4];
  logic         out_inv   [4];

  logic [31:0] u_col;
  logic        u_inv;
  logic [31:0] u_out;

  int checks   = 0;
  int failures = 0;

  mix_columns_engine #(.COLS_PER_CYCLE(1), .ENABLE_INV(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_state(in_state[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_state(out_state[0]), .out_inv(out_inv[0]));

  mix_columns_engine #(.COLS_PER_CYCLE(2), .ENABLE_INV(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_state(in_state[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_state(out_state[1]), .out_inv(out_inv[1]));

  mix_columns_engine #(.COLS_PER_CYCLE(4), .ENABLE_INV(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_state(in_state[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_state(out_state[2]), .out_inv(out_inv[2]));

  mix_columns_engine #(.COLS_PER_CYCLE(1), .ENABLE_INV(1'b0)) u_dut_noinv (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_state(in_state[3]), .in_inv(in_inv[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .out_state(out_state[3]), .out_inv(out_inv[3]));

  mix_column_unit #(.ENABLE_INV(1'b1)) u_unit (
    .col(u_col), .inv(u_inv), .col_out(u_out));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one block into an idle engine; returns after the accept edge
  task automatic send(input int d, input logic [127:0] s, input logic inv);
    in_valid[d] = 1'b1;
    in_state[d] = s;
    in_inv[d]   = inv;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  // Edges from the current point until out_valid; 99 on timeout
  task automatic wait_done(input int d, output int lat);
    int n;
    lat = 0;
    n   = 0;
    while (lat == 0 && n < 8) begin
      @(posedge clk); #1;
      n++;
      if (out_valid[d] === 1'b1) lat = n;
    end
    if (lat == 0) lat = 99;
  endtask

  task automatic consume(input int d);
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 ||
          out_state[d] !== 128'h0 || out_inv[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset dut%0d: in_ready=%b out_valid=%b out_state=%h out_inv=%b, need 1 0 0 0",
                 d, in_ready[d], out_valid[d], out_state[d], out_inv[d]);
      end
    end
  endtask

  task automatic test_column_unit();
    logic [31:0] vin  [6] = '{32'hDB135345, 32'hF20A225C, 32'h01010101,
                              32'hC6C6C6C6, 32'hD4D4D4D5, 32'h2D26314C};
    logic [31:0] vout [6] = '{32'h8E4DA1BC, 32'h9FDC589D, 32'h01010101,
                              32'hC6C6C6C6, 32'hD5D5D7D6, 32'h4D7EBDF8};
    for (int i = 0; i < 6; i++) begin
      u_col = vin[i]; u_inv = 1'b0; #1;
      checks++;
      if (u_out !== vout[i]) begin
        failures++;
        $display("FAIL unit_fwd[%0d]: got %h need %h", i, u_out, vout[i]);
      end
      u_col = vout[i]; u_inv = 1'b1; #1;
      checks++;
      if (u_out !== vin[i]) begin
        failures++;
        $display("FAIL unit_inv[%0d]: got %h need %h", i, u_out, vin[i]);
      end
    end
  endtask

  task automatic test_fips_all_widths();
    int lat_need [3] = '{4, 2, 1};
    int lat;
    for (int d = 0; d < 3; d++) begin
      send(d, c_fips_in, 1'b0);
      wait_done(d, lat);
      checks++;
      if (lat != lat_need[d] || out_state[d] !== c_fips_out || out_inv[d] !== 1'b0) begin
        failures++;
        $display("FAIL fips_fwd dut%0d: latency=%0d state=%h inv=%b, need latency=%0d state=%h inv=0",
                 d, lat, out_state[d], out_inv[d], lat_need[d], c_fips_out);
      end
      consume(d);
      send(d, c_fips_out, 1'b1);
      wait_done(d, lat);
      checks++;
      if (lat != lat_need[d] || out_state[d] !== c_fips_in || out_inv[d] !== 1'b1) begin
        failures++;
        $display("FAIL fips_inv dut%0d: latency=%0d state=%h inv=%b, need latency=%0d state=%h inv=1",
                 d, lat, out_state[d], out_inv[d], lat_need[d], c_fips_in);
      end
      consume(d);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    send(0, c_fips_in, 1'b0);
    wait_done(0, lat);
    in_valid[0] = 1'b1;
    in_state[0] = c_x;
    in_inv[0]   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 5) in_state[0] = c_fips_in;
      if (i == 7) in_state[0] = c_x;
      checks++;
      if (out_valid[0] !== 1'b1 || out_state[0] !== c_fips_out ||
          out_inv[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL backpressure cyc%0d: valid=%b state=%h inv=%b in_ready=%b, need 1 %h 0 0",
                 i, out_valid[0], out_state[0], out_inv[0], in_ready[0], c_fips_out);
      end
    end
    out_ready[0] = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_in_ready: got %b need 1", in_ready[0]);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept: out_valid=%b need 0", out_valid[0]);
    end
    wait_done(0, lat);
    checks++;
    if (lat != 4 || out_state[0] !== c_y) begin
      failures++;
      $display("FAIL b2b_result: latency=%0d state=%h, need latency=4 state=%h", lat, out_state[0], c_y);
    end
    consume(0);
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    send(0, c_x, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_state[0] !== 128'h0) begin
      failures++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b state=%h, need 1 0 0",
               in_ready[0], out_valid[0], out_state[0]);
    end
    send(0, c_x, 1'b0);
    wait_done(0, lat);
    checks++;
    if (lat != 4 || out_state[0] !== c_y) begin
      failures++;
      $display("FAIL after_reset: latency=%0d state=%h, need latency=4 state=%h", lat, out_state[0], c_y);
    end
    consume(0);
  endtask

  task automatic test_mode_interleave();
    logic [127:0] s_in   [4] = '{c_x, c_y, c_x, c_y};
    logic [127:0] s_need [4] = '{c_y, c_x, c_y, c_x};
    logic         m      [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send(0, s_in[i], m[i]);
      wait_done(0, lat);
      checks++;
      if (out_state[0] !== s_need[i] || out_inv[0] !== m[i]) begin
        failures++;
        $display("FAIL interleave[%0d]: state=%h inv=%b, need %h %b",
                 i, out_state[0], out_inv[0], s_need[i], m[i]);
      end
      consume(0);
    end
    send(3, c_x, 1'b1);
    wait_done(3, lat);
    checks++;
    if (lat != 4 || out_state[3] !== c_y || out_inv[3] !== 1'b0) begin
      failures++;
      $display("FAIL noinv: latency=%0d state=%h inv=%b, need 4 %h 0", lat, out_state[3], out_inv[3], c_y);
    end
    consume(3);
  endtask

  initial begin
    rst = 1'b1;
    u_col = '0;
    u_inv = 1'b0;
    for (int d = 0; d < 4; d++) begin
      in_valid[d]  = 1'b0;
      in_state[d]  = '0;
      in_inv[d]    = 1'b0;
      out_ready[d] = 1'b0;
    end
    test_reset();
    test_column_unit();
    test_fips_all_widths();
    test_back_to_back();
    test_reset_mid_busy();
    test_mode_interleave();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
